// File: rtl/morse_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : morse_tx_encoder
//  Purpose  : Sends one letter (A..Z) as International Morse on a keying line.
//  Revision : 1.0  initial release
// ============================================================================
module morse_tx_encoder #(
  parameter int DOT_TIME  = 20,
  parameter int DASH_TIME = 60,
  parameter int GAP_TIME  = 10,
  parameter int CHAR_GAP  = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [4:0] letter_i,
  input  logic       abort_i,
  output logic       ready_o,
  output logic       key_o,
  output logic       done_o,
  output logic       err_o
);

  // Timers count down to zero, so each interval loads its length minus one.
  localparam logic [6:0] c_DOT_LOAD  = 7'(DOT_TIME - 1);
  localparam logic [6:0] c_DASH_LOAD = 7'(DASH_TIME - 1);
  localparam logic [6:0] c_GAP_LOAD  = 7'(GAP_TIME - 1);
  localparam logic [6:0] c_CGAP_LOAD = 7'(CHAR_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_CGAP  = 2'd3
  } state_t;

  state_t     r_state;
  logic [6:0] r_timer;
  logic [3:0] r_shift;
  logic [2:0] r_len;
  logic [2:0] r_idx;

  logic [6:0] w_pat;
  logic [3:0] w_aligned;
  logic       w_last;

  always_comb begin
    w_pat = 7'd0;
    case (letter_i)
      5'd0:  w_pat = {3'd2, 4'b0001};
      5'd1:  w_pat = {3'd4, 4'b1000};
      5'd2:  w_pat = {3'd4, 4'b1010};
      5'd3:  w_pat = {3'd3, 4'b0100};
      5'd4:  w_pat = {3'd1, 4'b0000};
      5'd5:  w_pat = {3'd4, 4'b0010};
      5'd6:  w_pat = {3'd3, 4'b0110};
      5'd7:  w_pat = {3'd4, 4'b0000};
      5'd8:  w_pat = {3'd2, 4'b0000};
      5'd9:  w_pat = {3'd4, 4'b0111};
      5'd10: w_pat = {3'd3, 4'b0101};
      5'd11: w_pat = {3'd4, 4'b0100};
      5'd12: w_pat = {3'd2, 4'b0011};
      5'd13: w_pat = {3'd2, 4'b0010};
      5'd14: w_pat = {3'd3, 4'b0111};
      5'd15: w_pat = {3'd4, 4'b0110};
      5'd16: w_pat = {3'd4, 4'b1101};
      5'd17: w_pat = {3'd3, 4'b0010};
      5'd18: w_pat = {3'd3, 4'b0000};
      5'd19: w_pat = {3'd1, 4'b0001};
      5'd20: w_pat = {3'd3, 4'b0001};
      5'd21: w_pat = {3'd4, 4'b0001};
      5'd22: w_pat = {3'd3, 4'b0011};
      5'd23: w_pat = {3'd4, 4'b1001};
      5'd24: w_pat = {3'd4, 4'b1011};
      5'd25: w_pat = {3'd4, 4'b1100};
      default: w_pat = 7'd0;
    endcase
  end

  // Left-justify the code so the current element is always r_shift[3].
  assign w_aligned = w_pat[3:0] << (3'd4 - w_pat[6:4]);
  assign w_last    = (r_idx + 3'd1) >= r_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= 7'd0;
      r_shift <= 4'd0;
      r_len   <= 3'd0;
      r_idx   <= 3'd0;
      ready_o <= 1'b1;
      key_o   <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start_i) begin
          if (letter_i <= 5'd25) begin
            r_state <= S_MARK;
            r_shift <= w_aligned;
            r_len   <= w_pat[6:4];
            r_idx   <= 3'd0;
            r_timer <= w_aligned[3] ? c_DASH_LOAD : c_DOT_LOAD;
            key_o   <= 1'b1;
            ready_o <= 1'b0;
          end else begin
            err_o <= 1'b1;
          end
        end
      end else if (abort_i) begin
        r_state <= S_IDLE;
        r_timer <= 7'd0;
        key_o   <= 1'b0;
        ready_o <= 1'b1;
      end else if (r_timer != 7'd0) begin
        r_timer <= r_timer - 7'd1;
      end else begin
        case (r_state)
          S_MARK: begin
            key_o <= 1'b0;
            if (w_last) begin
              r_state <= S_CGAP;
              r_timer <= c_CGAP_LOAD;
            end else begin
              r_state <= S_SPACE;
              r_timer <= c_GAP_LOAD;
              r_shift <= {r_shift[2:0], 1'b0};
              r_idx   <= r_idx + 3'd1;
            end
          end
          S_SPACE: begin
            r_state <= S_MARK;
            r_timer <= r_shift[3] ? c_DASH_LOAD : c_DOT_LOAD;
            key_o   <= 1'b1;
          end
          S_CGAP: begin
            r_state <= S_IDLE;
            done_o  <= 1'b1;
            ready_o <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            key_o   <= 1'b0;
            ready_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_tx_encoder
//  Purpose  : Scoreboard bench; expected per-cycle outputs come from a Morse table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_tx_encoder;

  localparam int DOT  = 20;
  localparam int DASH = 60;
  localparam int GAP  = 10;
  localparam int CGAP = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [4:0] letter_i = 5'd0;
  logic       abort_i = 1'b0;
  logic       ready_o, key_o, done_o, err_o;

  morse_tx_encoder #(
    .DOT_TIME (DOT),
    .DASH_TIME(DASH),
    .GAP_TIME (GAP),
    .CHAR_GAP (CGAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .letter_i(letter_i),
    .abort_i (abort_i),
    .ready_o (ready_o),
    .key_o   (key_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  bit         mon_en = 1'b0;
  logic [3:0] q_exp[$];
  logic [3:0] r_e;

  string morse[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected word per cycle: {key, done, ready, err}; idle when nothing queued.
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      r_e = (q_exp.size() > 0) ? q_exp.pop_front() : 4'b0010;
      check_eq("cycle{key,done,ready,err}", {28'd0, key_o, done_o, ready_o, err_o}, {28'd0, r_e});
    end
  end

  task automatic push_n(input int n, input logic [3:0] v);
    for (int i = 0; i < n; i++) q_exp.push_back(v);
  endtask

  task automatic push_letter(input int idx);
    string p;
    p = morse[idx];
    for (int i = 0; i < p.len(); i++) begin
      push_n((p.getc(i) == "-") ? DASH : DOT, 4'b1000);
      if (i < p.len() - 1) push_n(GAP, 4'b0000);
    end
    push_n(CGAP, 4'b0000);
    q_exp.push_back(4'b0110);
  endtask

  task automatic send(input int idx);
    start_i  = 1'b1;
    letter_i = idx[4:0];
    if (idx <= 25) push_letter(idx);
    else q_exp.push_back(4'b0011);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q_exp.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", q_exp.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int list[6] = '{0, 13, 18, 25, 1, 9};
    #12;
    check_eq("rst_key", {31'd0, key_o}, 0);
    check_eq("rst_ready", {31'd0, ready_o}, 1);
    check_eq("rst_done", {31'd0, done_o}, 0);
    check_eq("rst_err", {31'd0, err_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    send(4);  wait_drain();
    send(19); wait_drain();

    // Q with a request mid-letter that must be ignored
    send(16);
    repeat (50) @(negedge clk);
    start_i = 1'b1;
    letter_i = 5'd0;
    @(negedge clk);
    start_i = 1'b0;
    wait_drain();

    foreach (list[i]) begin
      send(list[i]);
      wait_drain();
    end

    send(26); wait_drain();
    send(31); wait_drain();

    // Abort during first dash of Q at cycle 30
    start_i = 1'b1;
    letter_i = 5'd16;
    push_n(30, 4'b1000);
    @(negedge clk);
    start_i = 1'b0;
    repeat (29) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    repeat (5) @(negedge clk);
    send(4); wait_drain();

    // abort alone in IDLE does nothing; with start in IDLE start wins
    abort_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    letter_i = 5'd4;
    push_letter(4);
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    wait_drain();

    // Asynchronous reset mid-mark
    send(19);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    q_exp.delete();
    #1;
    check_eq("async_rst_key", {31'd0, key_o}, 0);
    check_eq("async_rst_ready", {31'd0, ready_o}, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back E,E with start held
    start_i = 1'b1;
    letter_i = 5'd4;
    push_letter(4);
    push_letter(4);
    repeat (62) @(negedge clk);
    start_i = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
